// File: rtl/dram_write_collector_if.sv
// Handshake bundle between the ALU writeback path, the write collector and the DRAM write port.
// Signal names are seen from the collector: i_* flow into it, o_* flow out of it.
interface dram_write_collector_if #(
    parameter int unsigned DW    = 16,
    parameter int unsigned VSIZE = 4,
    parameter int unsigned CSIZE = 8,
    parameter int unsigned GBW   = 32
);
    logic                    i_addrval_rdy;
    logic                    o_addrval_ack;
    logic [GBW-1:0]          i_addrval_addr;
    logic [CSIZE-1:0]        i_addrval_mask;

    logic                    i_alu_dat_rdy;
    logic                    o_alu_dat_ack;
    logic [VSIZE*DW-1:0]     i_alu_dat;

    logic                    o_dramw_rdy;
    logic                    i_dramw_ack;
    logic [GBW-1:0]          o_dramw_addr;
    logic [CSIZE*DW-1:0]     o_dramw_dat;
    logic [CSIZE-1:0]        o_dramw_mask;

    modport slave (
        input  i_addrval_rdy, i_addrval_addr, i_addrval_mask,
        input  i_alu_dat_rdy, i_alu_dat,
        input  i_dramw_ack,
        output o_addrval_ack, o_alu_dat_ack,
        output o_dramw_rdy, o_dramw_addr, o_dramw_dat, o_dramw_mask
    );

    modport master (
        output i_addrval_rdy, i_addrval_addr, i_addrval_mask,
        output i_alu_dat_rdy, i_alu_dat,
        output i_dramw_ack,
        input  o_addrval_ack, o_alu_dat_ack,
        input  o_dramw_rdy, o_dramw_addr, o_dramw_dat, o_dramw_mask
    );
endinterface

// File: rtl/dram_write_collector.sv
// Collects NBEAT ALU beats behind one address/mask transaction into a single DRAM line write.
// Optional WRITE_COLLECTOR_SKIP_EMPTY_EN: lines with an all-zero mask are consumed but never issued.
module dram_write_collector #(
    parameter int unsigned DW    = 16,
    parameter int unsigned VSIZE = 4,
    parameter int unsigned CSIZE = 8,
    parameter int unsigned GBW   = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    dram_write_collector_if.slave  io_bus
);
    localparam int unsigned NBEAT  = CSIZE / VSIZE;
    localparam int unsigned BEAT_W = VSIZE * DW;
    localparam int unsigned LINE_W = CSIZE * DW;
    localparam int unsigned BW     = (NBEAT > 1) ? $clog2(NBEAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_OUT     = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [BW-1:0]       r_beat;
    logic [GBW-1:0]      r_addr;
    logic [CSIZE-1:0]    r_mask;
    logic [LINE_W-1:0]   r_dat;
    logic                w_addr_ack;
    logic                w_dat_ack;
    logic                w_last_beat;

    // Next state and the two combinational acks; acks are held low during reset.
    always_comb begin
        w_next_state = r_state;
        w_addr_ack   = 1'b0;
        w_dat_ack    = 1'b0;
        w_last_beat  = (r_beat == BW'(NBEAT - 1));
        case (r_state)
            S_IDLE: begin
                w_addr_ack = io_bus.i_addrval_rdy & ~i_rst;
                if (w_addr_ack) begin
                    w_next_state = S_COLLECT;
                end
            end
            S_COLLECT: begin
                w_dat_ack = io_bus.i_alu_dat_rdy & ~i_rst;
                if (w_dat_ack && w_last_beat) begin
`ifdef WRITE_COLLECTOR_SKIP_EMPTY_EN
                    w_next_state = (r_mask == '0) ? S_IDLE : S_OUT;
`else
                    w_next_state = S_OUT;
`endif
                end
            end
            S_OUT: begin
                if (io_bus.i_dramw_ack) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Line buffer doubles as the output register; it is only presented while in S_OUT.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_beat <= '0;
            r_addr <= '0;
            r_mask <= '0;
            r_dat  <= '0;
        end else begin
            if (w_addr_ack) begin
                r_addr <= io_bus.i_addrval_addr;
                r_mask <= io_bus.i_addrval_mask;
                r_beat <= '0;
            end
            if (w_dat_ack) begin
                for (int unsigned b = 0; b < NBEAT; b++) begin
                    if (r_beat == BW'(b)) begin
                        r_dat[b*BEAT_W +: BEAT_W] <= io_bus.i_alu_dat;
                    end
                end
                r_beat <= w_last_beat ? '0 : r_beat + BW'(1);
            end
        end
    end

    assign io_bus.o_addrval_ack = w_addr_ack;
    assign io_bus.o_alu_dat_ack = w_dat_ack;
    assign io_bus.o_dramw_rdy   = (r_state == S_OUT);
    assign io_bus.o_dramw_addr  = r_addr;
    assign io_bus.o_dramw_dat   = r_dat;
    assign io_bus.o_dramw_mask  = r_mask;

endmodule

// File: tb/tb_dram_write_collector.sv
// Directed bench for dram_write_collector: vector table of lines plus hand-written
// sequences for reset, early offers, empty masks, mid-line reset and random backpressure.
module tb_dram_write_collector;
    localparam int unsigned DW    = 16;
    localparam int unsigned VSIZE = 4;
    localparam int unsigned CSIZE = 8;
    localparam int unsigned GBW   = 32;

    typedef struct {
        logic [31:0]  addr;
        logic [7:0]   mask;
        logic [63:0]  b0;
        logic [63:0]  b1;
        logic [31:0]  exp_addr;
        logic [127:0] exp_dat;
        logic [7:0]   exp_mask;
    } vec_t;

    logic clk;
    logic rst;
    int   n_err;
    int   n_chk;

    dram_write_collector_if #(.DW(DW), .VSIZE(VSIZE), .CSIZE(CSIZE), .GBW(GBW)) bus ();

    dram_write_collector #(.DW(DW), .VSIZE(VSIZE), .CSIZE(CSIZE), .GBW(GBW)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [175:0] act, input logic [175:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic realign();
        @(posedge clk);
        #1;
    endtask

    task automatic send_addr(input logic [31:0] a, input logic [7:0] m, output int waited);
        bus.i_addrval_addr = a;
        bus.i_addrval_mask = m;
        bus.i_addrval_rdy  = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!bus.o_addrval_ack && waited < 1000);
        chk("addrval accepted", bus.o_addrval_ack, 1);
        realign();
        bus.i_addrval_rdy = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] d);
        int waited;
        bus.i_alu_dat     = d;
        bus.i_alu_dat_rdy = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!bus.o_alu_dat_ack && waited < 1000);
        chk("alu beat accepted", bus.o_alu_dat_ack, 1);
        realign();
        bus.i_alu_dat_rdy = 1'b0;
    endtask

    // Expects the request on the first cycle after the last beat, then acks it at once.
    task automatic recv_line(input string tag, input logic [31:0] ea, input logic [127:0] ed,
                             input logic [7:0] em);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.o_dramw_rdy && n < 50);
        chk({tag, " latency"}, 176'(n), 176'(1));
        chk({tag, " addr"}, bus.o_dramw_addr, ea);
        chk({tag, " dat"}, bus.o_dramw_dat, ed);
        chk({tag, " mask"}, bus.o_dramw_mask, em);
        bus.i_dramw_ack = bus.o_dramw_rdy;
        realign();
        bus.i_dramw_ack = 1'b0;
        chk({tag, " rdy fall"}, bus.o_dramw_rdy, 0);
    endtask

    function automatic logic [63:0] gen_beat(input int i, input int b);
        logic [63:0] r;
        for (int j = 0; j < 4; j++) begin
            r[j*16 +: 16] = 16'(i * 16 + b * 4 + j) ^ 16'h5A00;
        end
        return r;
    endfunction

    initial begin
        vec_t vecs[4];
        int   w;
        logic seen;
        int   got;
        int   cyc;
        logic pend;
        logic [175:0] prev;
        logic [175:0] cur;

        vecs[0] = '{32'h0000_0100, 8'hFF, 64'h0003_0002_0001_0000, 64'h0007_0006_0005_0004,
                    32'h0000_0100, 128'h0007_0006_0005_0004_0003_0002_0001_0000, 8'hFF};
        vecs[1] = '{32'hDEAD_BEEF, 8'h5A, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
                    32'hDEAD_BEEF, 128'h5555_6666_7777_8888_1111_2222_3333_4444, 8'h5A};
        vecs[2] = '{32'hFFFF_FFFF, 8'h81, 64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF,
                    32'hFFFF_FFFF, 128'h0000_FFFF_0000_FFFF_FFFF_0000_FFFF_0000, 8'h81};
        vecs[3] = '{32'h0000_0000, 8'h01, 64'hABCD_EF01_2345_6789, 64'h0F0F_F0F0_1234_8765,
                    32'h0000_0000, 128'h0F0F_F0F0_1234_8765_ABCD_EF01_2345_6789, 8'h01};

        n_err = 0;
        n_chk = 0;
        rst = 1'b1;
        bus.i_addrval_rdy  = 1'b1;
        bus.i_addrval_addr = 32'h1234_5678;
        bus.i_addrval_mask = 8'hFF;
        bus.i_alu_dat_rdy  = 1'b1;
        bus.i_alu_dat      = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.i_dramw_ack    = 1'b0;

        // Reset held with every sender offering
        repeat (5) begin
            @(negedge clk);
            chk("reset addrval_ack", bus.o_addrval_ack, 0);
            chk("reset alu_ack", bus.o_alu_dat_ack, 0);
            chk("reset dramw_rdy", bus.o_dramw_rdy, 0);
        end
        chk("reset dramw_addr", bus.o_dramw_addr, 0);
        chk("reset dramw_dat", bus.o_dramw_dat, 0);
        chk("reset dramw_mask", bus.o_dramw_mask, 0);
        bus.i_addrval_rdy = 1'b0;
        bus.i_alu_dat_rdy = 1'b0;
        realign();
        rst = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.o_dramw_rdy) seen = 1'b1;
        end
        chk("no request after reset", seen, 0);
        realign();

        // Vector table: back-to-back single lines
        for (int i = 0; i < 4; i++) begin
            send_addr(vecs[i].addr, vecs[i].mask, w);
            send_beat(vecs[i].b0);
            send_beat(vecs[i].b1);
            recv_line($sformatf("vec%0d", i), vecs[i].exp_addr, vecs[i].exp_dat, vecs[i].exp_mask);
        end

        // Early data in IDLE, early addrval and data during OUT
        bus.i_alu_dat     = 64'hA003_A002_A001_A000;
        bus.i_alu_dat_rdy = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("early alu ack in idle", bus.o_alu_dat_ack, 0);
        end
        realign();
        send_addr(32'h0000_0200, 8'hF0, w);
        send_beat(64'hA003_A002_A001_A000);
        send_beat(64'hB003_B002_B001_B000);
        bus.i_addrval_addr = 32'h0000_0300;
        bus.i_addrval_mask = 8'h0F;
        bus.i_addrval_rdy  = 1'b1;
        bus.i_alu_dat      = 64'hC003_C002_C001_C000;
        bus.i_alu_dat_rdy  = 1'b1;
        @(negedge clk);
        chk("early dramw_rdy", bus.o_dramw_rdy, 1);
        chk("early addrval ack in out", bus.o_addrval_ack, 0);
        chk("early alu ack in out", bus.o_alu_dat_ack, 0);
        chk("early addr", bus.o_dramw_addr, 32'h0000_0200);
        chk("early dat", bus.o_dramw_dat, 128'hB003_B002_B001_B000_A003_A002_A001_A000);
        chk("early mask", bus.o_dramw_mask, 8'hF0);
        bus.i_dramw_ack = 1'b1;
        realign();
        bus.i_dramw_ack = 1'b0;
        chk("early rdy fall", bus.o_dramw_rdy, 0);
        send_addr(32'h0000_0300, 8'h0F, w);
        chk("addrval accepted cycle after ack", 176'(w), 176'(1));
        send_beat(64'hC003_C002_C001_C000);
        send_beat(64'hD003_D002_D001_D000);
        recv_line("early2", 32'h0000_0300, 128'hD003_D002_D001_D000_C003_C002_C001_C000, 8'h0F);

        // All-zero mask
        send_addr(32'h0000_0400, 8'h00, w);
        send_beat(64'hE003_E002_E001_E000);
        send_beat(64'hF003_F002_F001_F000);
`ifdef WRITE_COLLECTOR_SKIP_EMPTY_EN
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.o_dramw_rdy) seen = 1'b1;
        end
        chk("empty mask no request", seen, 0);
        realign();
`else
        recv_line("mask0", 32'h0000_0400, 128'hF003_F002_F001_F000_E003_E002_E001_E000, 8'h00);
`endif
        send_addr(32'h0000_0500, 8'h3C, w);
        chk("after mask0 addr accepted at once", 176'(w), 176'(1));
        send_beat(64'h1003_1002_1001_1000);
        send_beat(64'h2003_2002_2001_2000);
        recv_line("after mask0", 32'h0000_0500, 128'h2003_2002_2001_2000_1003_1002_1001_1000, 8'h3C);

        // Reset after one of two beats
        send_addr(32'h0000_0600, 8'hFF, w);
        send_beat(64'h6666_6666_6666_6666);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midreset dramw_rdy", bus.o_dramw_rdy, 0);
        chk("midreset addr", bus.o_dramw_addr, 0);
        chk("midreset dat", bus.o_dramw_dat, 0);
        chk("midreset mask", bus.o_dramw_mask, 0);
        realign();
        rst = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.o_dramw_rdy) seen = 1'b1;
        end
        chk("midreset no request", seen, 0);
        realign();
        send_addr(32'h0000_0700, 8'hAA, w);
        chk("midreset addr accepted at once", 176'(w), 176'(1));
        send_beat(64'h7003_7002_7001_7000);
        send_beat(64'h8003_8002_8001_8000);
        recv_line("post reset", 32'h0000_0700, 128'h8003_8002_8001_8000_7003_7002_7001_7000, 8'hAA);

        // 100 lines under random 30% DRAM acceptance
        fork
            begin
                int sw;
                for (int i = 0; i < 100; i++) begin
                    send_addr(32'h1000_0000 + 32'(i), 8'(i * 37) | 8'h01, sw);
                    send_beat(gen_beat(i, 0));
                    send_beat(gen_beat(i, 1));
                end
            end
            begin
                got  = 0;
                cyc  = 0;
                pend = 1'b0;
                prev = '0;
                while (got < 100 && cyc < 5000) begin
                    @(negedge clk);
                    cyc++;
                    if (bus.o_dramw_rdy) begin
                        cur = {8'h00, bus.o_dramw_addr, bus.o_dramw_dat, bus.o_dramw_mask};
                        if (pend) chk("bp payload stable", cur, prev);
                        if ($urandom_range(0, 99) < 30) begin
                            bus.i_dramw_ack = 1'b1;
                            chk($sformatf("bp line %0d", got), cur,
                                {8'h00, 32'h1000_0000 + 32'(got), gen_beat(got, 1), gen_beat(got, 0),
                                 8'(got * 37) | 8'h01});
                            got++;
                            pend = 1'b0;
                        end else begin
                            bus.i_dramw_ack = 1'b0;
                            pend = 1'b1;
                            prev = cur;
                        end
                    end else begin
                        bus.i_dramw_ack = 1'b0;
                        pend = 1'b0;
                    end
                end
                realign();
                bus.i_dramw_ack = 1'b0;
                chk("bp lines received", 176'(got), 176'(100));
            end
        join
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.o_dramw_rdy) seen = 1'b1;
        end
        chk("bp no duplicate request", seen, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
